// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter.
// Holds the framebuffer geometry, the read-owner tag encoding and the
// arbiter mode encoding.
package fb_pkg;

  localparam int FB_AW    = 12;
  localparam int FB_DW    = 12;
  localparam int FB_DEPTH = 4096;

  // Which requester a pending SRAM read belongs to.
  typedef enum logic {
    OWN_SCAN = 1'b0,
    OWN_REND = 1'b1
  } owner_e;

  // IDLE: renderer competes through wr_req. CLEAR: the fill engine competes.
  typedef enum logic {
    M_IDLE  = 1'b0,
    M_CLEAR = 1'b1
  } mode_e;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Two-stage {valid, owner} shift register that follows each issued SRAM read
// so the returning FB_Q word can be steered to the right requester.
// Ports:
//   clk_i, reset_i    clock, asynchronous active-high reset
//   vld_i, own_i      a read is issued this cycle and who owns it
//   scan_vld_o        stage-2 tag belongs to scan-out
//   rend_vld_o        stage-2 tag belongs to the renderer
module fb_rd_tag_pipe
  import fb_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic vld_i,
  input  logic own_i,
  output logic scan_vld_o,
  output logic rend_vld_o
);

  logic vld1_q, own1_q;
  logic vld2_q, own2_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld1_q <= 1'b0;
      own1_q <= 1'b0;
      vld2_q <= 1'b0;
      own2_q <= 1'b0;
    end else begin
      vld1_q <= vld_i;
      own1_q <= own_i;
      vld2_q <= vld1_q;
      own2_q <= own1_q;
    end
  end

  assign scan_vld_o = vld2_q & (own2_q == OWN_SCAN);
  assign rend_vld_o = vld2_q & (own2_q == OWN_REND);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer SRAM arbiter with a built-in bulk-clear engine.
// Scan-out reads win each slot by default; the renderer side (wr_req in IDLE,
// the clear engine in CLEAR) wins when scan-out is idle or after STARVE_LIMIT
// consecutive losses. The winning access is registered onto the FB_* pins.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   rd_req/rd_addr/rd_gnt            scan-out read request and grant
//   rd_valid/rd_data                 scan-out read return
//   wr_req/wr_we/wr_addr/wr_wdata    renderer request
//   wr_gnt/wr_rvalid/wr_rdata        renderer grant and read return
//   clear_start/clear_color          start a full fill with one colour
//   clear_busy/clear_done            fill status, done pulse on last issue
//   FB_CEN/FB_WEN/FB_A/FB_D/FB_Q     SRAM macro pins
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DEPTH        = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_req,
  input  logic [FB_AW-1:0] rd_addr,
  output logic             rd_gnt,
  output logic             rd_valid,
  output logic [FB_DW-1:0] rd_data,
  input  logic             wr_req,
  input  logic             wr_we,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [FB_DW-1:0] wr_wdata,
  output logic             wr_gnt,
  output logic             wr_rvalid,
  output logic [FB_DW-1:0] wr_rdata,
  input  logic             clear_start,
  input  logic [FB_DW-1:0] clear_color,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             FB_CEN,
  output logic             FB_WEN,
  output logic [FB_AW-1:0] FB_A,
  output logic [FB_DW-1:0] FB_D,
  input  logic [FB_DW-1:0] FB_Q
);

  localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(DEPTH - 1);
  localparam logic [2:0]       STARVE_MAX = 3'(STARVE_LIMIT);

  mode_e            mode_q, mode_d;
  logic             clearing;
  logic [2:0]       starve_q, starve_d;
  logic [FB_AW-1:0] clr_addr_q, clr_addr_d;
  logic [FB_DW-1:0] color_q, color_d;
  logic             cen_q, wen_q;
  logic [FB_AW-1:0] a_q;
  logic [FB_DW-1:0] d_q;

  logic             rend_req, rend_win, rd_win, wr_win, clr_win, issue;
  logic             iss_we;
  logic [FB_AW-1:0] iss_addr;
  logic [FB_DW-1:0] iss_wdata;
  logic             tag_vld;
  owner_e           tag_own;

  // Mode FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= M_IDLE;
    else       mode_q <= mode_d;
  end

  // Mode FSM: next state. A start pulse during a clear is ignored.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      M_IDLE:  if (clear_start) mode_d = M_CLEAR;
      M_CLEAR: if (clr_win && clr_addr_q == LAST_ADDR) mode_d = M_IDLE;
      default: mode_d = M_IDLE;
    endcase
  end

  // Mode FSM: outputs
  always_comb begin
    clearing   = (mode_q == M_CLEAR);
    clear_busy = clearing;
    clear_done = clr_win && (clr_addr_q == LAST_ADDR);
  end

  // Arbitration. Grants are forced low while reset is held.
  always_comb begin
    rend_req = clearing | wr_req;
    rend_win = ~reset & rend_req & (~rd_req | (starve_q == STARVE_MAX));
    rd_win   = ~reset & rd_req & ~rend_win;
    wr_win   = rend_win & ~clearing;
    clr_win  = rend_win & clearing;
    issue    = rd_win | rend_win;
    rd_gnt   = rd_win;
    wr_gnt   = wr_win;
  end

  // Loss streak of the renderer side; it saturates naturally because a
  // streak at the limit always wins the next slot.
  always_comb begin
    if (rend_req && !rend_win && !reset) starve_d = starve_q + 3'd1;
    else                                 starve_d = 3'd0;
  end

  // Source select for the registered SRAM command. Scan reads leave FB_D as is.
  always_comb begin
    if (rd_win) begin
      iss_we    = 1'b0;
      iss_addr  = rd_addr;
      iss_wdata = d_q;
    end else if (wr_win) begin
      iss_we    = wr_we;
      iss_addr  = wr_addr;
      iss_wdata = wr_wdata;
    end else begin
      iss_we    = 1'b1;
      iss_addr  = clr_addr_q;
      iss_wdata = color_q;
    end
  end

  // Clear engine address and colour capture
  always_comb begin
    clr_addr_d = clr_addr_q;
    color_d    = color_q;
    if (clear_start && !clearing) begin
      clr_addr_d = '0;
      color_d    = clear_color;
    end else if (clr_win) begin
      clr_addr_d = clr_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q   <= 3'd0;
      clr_addr_q <= '0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      starve_q   <= starve_d;
      clr_addr_q <= clr_addr_d;
      cen_q      <= ~issue;
      if (issue) begin
        wen_q <= ~iss_we;
        a_q   <= iss_addr;
        d_q   <= iss_wdata;
      end
    end
  end

  // Fill colour is pure data and is always rewritten before a clear uses it.
  always_ff @(posedge clk) begin
    color_q <= color_d;
  end

  // Only reads are tagged; the owner is whoever won the slot.
  always_comb begin
    tag_vld = rd_win | (wr_win & ~wr_we);
    tag_own = wr_win ? OWN_REND : OWN_SCAN;
  end

  fb_rd_tag_pipe u_tag (
    .clk_i      (clk),
    .reset_i    (reset),
    .vld_i      (tag_vld),
    .own_i      (tag_own),
    .scan_vld_o (rd_valid),
    .rend_vld_o (wr_rvalid)
  );

  assign FB_CEN   = cen_q;
  assign FB_WEN   = wen_q;
  assign FB_A     = a_q;
  assign FB_D     = d_q;
  assign rd_data  = FB_Q;
  assign wr_rdata = FB_Q;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer SRAM arbiter and sequencer. Shares the 4096×12 framebuffer between two requesters: the display scan-out reader (read-only, latency-sensitive) and the sprite renderer (read/write). It also contains a built-in bulk-clear engine that fills the whole framebuffer with one colour, so the renderer no longer spends 4096 cycles on its own clear pass. It sits between both requesters and the SRAM macro and is the only driver of the FB_* pins.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles on the renderer side before it is forced a grant.
- DEPTH, 4096: framebuffer words; the address width is fixed at 12.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  reset, asynchronous, active-high.
- rd_req  in  1  scan-out read request.
- rd_addr  in  12  scan-out address.
- rd_gnt  out  1  combinational grant; the request is accepted in the cycle rd_req & rd_gnt.
- rd_valid  out  1  scan-out read data valid.
- rd_data  out  12  equals FB_Q.
- wr_req  in  1  renderer request.
- wr_we  in  1  1 = write, 0 = read.
- wr_addr  in  12  renderer address.
- wr_wdata  in  12  renderer write data.
- wr_gnt  out  1  combinational grant.
- wr_rvalid  out  1  renderer read data valid.
- wr_rdata  out  12  equals FB_Q.
- clear_start  in  1  single-cycle pulse that starts a full clear.
- clear_color  in  12  fill colour; sampled on the clear_start cycle.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when the clear completes.
- FB_CEN  out  1  SRAM chip enable, active-low, registered.
- FB_WEN  out  1  SRAM write enable, active-low, registered.
- FB_A  out  12  registered address.
- FB_D  out  12  registered write data.
- FB_Q  in  12  SRAM read data, valid the cycle after the SRAM samples its address.

## Operation
- Modes are IDLE and CLEAR.
  - IDLE → CLEAR on clear_start.
  - CLEAR → IDLE after word 4095 is issued; clear_done pulses in that same cycle.
- The renderer side is the source that competes against scan-out for each slot:
  - In IDLE it is wr_req.
  - In CLEAR it is the clear engine, which always requests. wr_gnt = 0 throughout CLEAR.
- Arbitration each cycle:
  - Scan-out wins by default.
  - The renderer side wins if scan-out is not requesting, or if starve_cnt == STARVE_LIMIT.
- starve_cnt (3 bits):
  - Increments on each cycle the renderer side requests and loses.
  - Clears when the renderer side is granted or is not requesting.
- Issue on grant, registered at the end of the grant cycle:
  - FB_CEN = 0.
  - FB_WEN = ~we. Scan-out reads use we = 0; clear writes use we = 1.
  - FB_A = address.
  - FB_D = write data.
- A cycle with no grant drives FB_CEN = 1; FB_WEN, FB_A and FB_D hold their values.
- Clear engine:
  - clr_addr resets to 0 on clear_start.
  - It increments by 1 on each granted clear slot and writes clear_color to every word.
  - The clear ends after the slot that issues address 4095. It never wraps.
- Read tagging: a 2-stage shift register carries {valid, owner} per issued read.
  - At stage 2, rd_valid or wr_rvalid asserts according to the owner.
  - Writes carry no tag.
- clear_start while clear_busy = 1 is ignored.
- clear_start and wr_req in the same cycle: the wr_req is arbitrated normally in that cycle, and CLEAR starts on the next cycle.

## Timing
- A grant in cycle N means:
  - FB_* are presented in cycle N+1.
  - The SRAM samples at the end of N+1.
  - FB_Q and the matching *_rvalid / rd_valid are valid in N+2.
- Read latency is 2 cycles from grant. Back-to-back grants give one word per cycle.
- Full clear with no scan-out traffic: clear_busy is high for 4096 cycles, and clear_done pulses in the cycle of the last grant.
- Reset values:
  - FB_CEN = 1, FB_WEN = 1, FB_A = 0, FB_D = 0.
  - rd_valid = 0, wr_rvalid = 0, clear_busy = 0, clear_done = 0.
  - starve_cnt = 0, tags cleared, mode = IDLE.
  - rd_gnt and wr_gnt are 0 while reset is asserted.
- Reset mid-clear or mid-read aborts immediately. Pending read tags are discarded, and no valid pulse is produced afterwards.

## Structure
- Shared package fb_pkg holds:
  - FB_AW = 12, FB_DW = 12, FB_DEPTH = 4096.
  - The owner enum: OWN_SCAN = 0, OWN_REND = 1.
  - The mode enum: M_IDLE, M_CLEAR.
- One sub-module, fb_rd_tag_pipe: the 2-stage valid/owner shift register, with asynchronous reset.
- Arbitration, starve counter and clear engine are inline in fb_arbiter.

## Test plan
- Scan-out only:
  - Stimulus: rd_req held high with rd_addr = 0, 1, 2…
  - Response: rd_gnt every cycle, FB_A = 0, 1, 2 starting one cycle later, rd_valid two cycles after each grant.
- Renderer only:
  - Stimulus: write 0xABC to address 0x040, then a read of 0x040.
  - Response: FB_WEN = 0 then 1, wr_rvalid two cycles after the read grant, wr_rdata = 0xABC (SRAM model).
- Starvation:
  - Stimulus: rd_req and wr_req held continuously, STARVE_LIMIT = 4.
  - Response: wr_gnt once every 5th cycle; scan-out gets the other 4.
- Clear:
  - Stimulus: clear_start with clear_color = 0x123 and no scan-out.
  - Response: clear_busy high for 4096 cycles, every word reads 0x123, clear_done is a single pulse, wr_gnt = 0 throughout.
- Clear under scan-out load:
  - Stimulus: a clear runs while rd_req is held high.
  - Response: the clear advances one word per 5 cycles and still ends at 4095. A second clear_start mid-clear is ignored.
- Reset mid-clear:
  - Stimulus: assert reset at clr_addr = 100.
  - Response: all outputs at reset values, no rd_valid or wr_rvalid afterwards, next clear_start restarts from 0.
